braid_input_sequencer: RTL and testbench

- Upstream dispense controller for the 8-input mixer braid.
- Meters reagent into each braid input by opening that input's valve for a programmed number of clock ticks, one channel at a time, in ascending order.
- After the last channel it waits a fixed settle interval so fluid can traverse the 16 mixer columns, then signals completion.
- Drives the valve-control layer that feeds input_0..input_7 of the braid.

---
 rtl/braid_seq_pkg.sv | 35 +++
 rtl/braid_seq_timer.sv | 33 +++
 rtl/braid_input_sequencer.sv | 171 +++++++++++++++++
 tb/tb_braid_input_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/braid_seq_pkg.sv
// Shared constants, widths and state encoding for the braid input sequencer.
package braid_seq_pkg;

  localparam int N_IN          = 8;
  localparam int DUR_W         = 8;
  localparam int GAP_CYCLES    = 2;
  localparam int SETTLE_CYCLES = 16;

  localparam int CHAN_W = $clog2(N_IN);
  localparam int TICK_W = DUR_W + CHAN_W;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int TMR_W = max3(DUR_W, $clog2(SETTLE_CYCLES + 1), $clog2(GAP_CYCLES + 1));

  typedef enum logic [2:0] {
    IDLE,
    DISPENSE,
    GAP,
    SETTLE,
    DONE
  } state_e;

  function automatic logic [N_IN-1:0] chan_onehot(input logic [CHAN_W-1:0] c);
    logic [N_IN-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/braid_seq_timer.sv
// Loadable down-counter shared by the dispense, gap and settle intervals.
module braid_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/braid_input_sequencer.sv
// Meters reagent into the eight braid inputs one channel at a time,
// then waits for the mixer to settle and pulses done.
module braid_input_sequencer
  import braid_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_IN*DUR_W-1:0] dur_in,
  input  logic                  abort,
  output logic [N_IN-1:0]       valve_open,
  output logic [CHAN_W-1:0]     chan_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [TICK_W-1:0]     total_ticks
);

  localparam logic [TMR_W-1:0]  GAP_LOAD    = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN   = CHAN_W'(N_IN - 1);

  state_e                  state_q, state_d;
  logic [N_IN*DUR_W-1:0]   dur_q, dur_d;
  logic [CHAN_W-1:0]       chan_q, chan_d;
  logic [N_IN-1:0]         valve_q, valve_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic [TICK_W-1:0]       ticks_q, ticks_d;

  logic                    tmr_load;
  logic [TMR_W-1:0]        tmr_val;
  logic                    tmr_zero;

  logic                    enter;
  logic [CHAN_W-1:0]       enter_chan;
  logic [DUR_W-1:0]        enter_dur;
  logic [CHAN_W-1:0]       chan_next;
  logic [DUR_W-1:0]        cur_dur;

  braid_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    chan_d     = chan_q;
    valve_d    = valve_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    enter      = 1'b0;
    chan_next  = chan_q + CHAN_W'(1);
    cur_dur    = dur_q[chan_q*DUR_W +: DUR_W];
    enter_chan = chan_q;
    enter_dur  = cur_dur;
    ticks_d    = (valve_q != '0) ? ticks_q + TICK_W'(1) : ticks_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dur_d     = dur_in;
          ticks_d   = '0;
          enter     = 1'b1;
          enter_chan = '0;
          enter_dur = dur_in[DUR_W-1:0];
        end
      end
      DISPENSE: begin
        if (tmr_zero) begin
          valve_d = '0;
          if (chan_q == LAST_CHAN) begin
            state_d  = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
          end else if (cur_dur == '0) begin
            // A skipped channel flows straight into the next one, no flush gap
            enter      = 1'b1;
            enter_chan = chan_next;
            enter_dur  = dur_q[chan_next*DUR_W +: DUR_W];
          end else begin
            chan_d   = chan_next;
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (tmr_zero) begin
          enter = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valve_d = '0;
      end
    endcase

    if (enter) begin
      state_d  = DISPENSE;
      chan_d   = enter_chan;
      tmr_load = 1'b1;
      if (enter_dur == '0) begin
        valve_d = '0;
        tmr_val = '0;
      end else begin
        valve_d = chan_onehot(enter_chan);
        tmr_val = TMR_W'(enter_dur) - TMR_W'(1);
      end
    end

    // Abort wins over any expiry; the final open cycle is not counted
    if (abort && (state_q == DISPENSE || state_q == GAP || state_q == SETTLE)) begin
      state_d   = IDLE;
      valve_d   = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      ticks_d   = ticks_q;
      tmr_load  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      chan_q    <= '0;
      valve_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ticks_q   <= '0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      chan_q    <= chan_d;
      valve_q   <= valve_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ticks_q   <= ticks_d;
    end
  end

  assign valve_open  = valve_q;
  assign chan_idx    = chan_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign total_ticks = ticks_q;

endmodule

// File: tb/tb_braid_input_sequencer.sv
// Directed checks of the braid input sequencer against hand-computed cycle tables.
module tb_braid_input_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] dur_in;
  logic        abort;
  logic [7:0]  valve_open;
  logic [2:0]  chan_idx;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [10:0] total_ticks;

  braid_input_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dur_in      (dur_in),
    .abort       (abort),
    .valve_open  (valve_open),
    .chan_idx    (chan_idx),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .total_ticks (total_ticks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          scen;
    int          cyc;
    logic [7:0]  valve;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [10:0] ticks;
    logic        chkChan;
    logic [2:0]  chan;
  } vec_t;

  vec_t vecs[$];

  logic [7:0]  trValve   [0:127];
  logic [2:0]  trChan    [0:127];
  logic        trBusy    [0:127];
  logic        trDone    [0:127];
  logic        trAborted [0:127];
  logic [10:0] trTicks   [0:127];
  logic [7:0]  valveOr;
  int          multiHot;
  int          doneCount;
  int          abortedCount;

  int nCompared;
  int nFailed;

  localparam logic [63:0] ALL3  = 64'h0303030303030303;
  localparam logic [63:0] MIXED = 64'h0200000000000005;
  localparam logic [63:0] ALL0  = 64'h0000000000000000;

  function automatic void addVec(input int scen, input int cyc, input logic [7:0] valve,
                                 input logic b, input logic d, input logic a,
                                 input logic [10:0] ticks, input logic chkChan,
                                 input logic [2:0] chan);
    vec_t v;
    v.scen = scen; v.cyc = cyc; v.valve = valve; v.busy = b; v.done = d;
    v.aborted = a; v.ticks = ticks; v.chkChan = chkChan; v.chan = chan;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic recordCycle(input int c);
    trValve[c]   = valve_open;
    trChan[c]    = chan_idx;
    trBusy[c]    = busy;
    trDone[c]    = done;
    trAborted[c] = aborted;
    trTicks[c]   = total_ticks;
    valveOr      = valveOr | valve_open;
    if ($countones(valve_open) > 1) multiHot++;
    if (done === 1'b1) doneCount++;
    if (aborted === 1'b1) abortedCount++;
  endtask

  // Cycle 0 is the cycle in which start is held high.
  task automatic applyStimulus(input logic [63:0] durs, input int ncyc,
                               input int abortCyc, input int start2Cyc);
    valveOr = '0; multiHot = 0; doneCount = 0; abortedCount = 0;
    @(posedge clk); #1;
    dur_in = durs;
    start  = 1'b1;
    abort  = 1'b0;
    recordCycle(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == start2Cyc);
      abort = (c == abortCyc);
      recordCycle(c);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkOutput(input int scen, input int expDone, input int expAborted);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        cmp("valve_open",  vecs[i].cyc, 32'(trValve[vecs[i].cyc]),   32'(vecs[i].valve));
        cmp("busy",        vecs[i].cyc, 32'(trBusy[vecs[i].cyc]),    32'(vecs[i].busy));
        cmp("done",        vecs[i].cyc, 32'(trDone[vecs[i].cyc]),    32'(vecs[i].done));
        cmp("aborted",     vecs[i].cyc, 32'(trAborted[vecs[i].cyc]), 32'(vecs[i].aborted));
        cmp("total_ticks", vecs[i].cyc, 32'(trTicks[vecs[i].cyc]),   32'(vecs[i].ticks));
        if (vecs[i].chkChan) begin
          cmp("chan_idx",  vecs[i].cyc, 32'(trChan[vecs[i].cyc]),    32'(vecs[i].chan));
        end
      end
    end
    cmp("done_pulses",    scen, 32'(doneCount),    32'(expDone));
    cmp("aborted_pulses", scen, 32'(abortedCount), 32'(expAborted));
    cmp("valve_onehot",   scen, 32'(multiHot),     32'd0);
  endtask

  initial begin
    nCompared = 0;
    nFailed   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    dur_in = '0;

    // Scenario 0: all durations 3
    for (int k = 0; k < 8; k++) begin
      addVec(0, 1 + 5*k, 8'(1 << k), 1, 0, 0, 11'(3*k),     1, 3'(k));
      addVec(0, 3 + 5*k, 8'(1 << k), 1, 0, 0, 11'(3*k + 2), 1, 3'(k));
      if (k < 7) addVec(0, 4 + 5*k, 8'h00, 1, 0, 0, 11'(3*k + 3), 0, 3'd0);
    end
    addVec(0, 39, 8'h00, 1, 0, 0, 11'd24, 0, 3'd0);
    addVec(0, 54, 8'h00, 1, 0, 0, 11'd24, 0, 3'd0);
    addVec(0, 55, 8'h00, 1, 1, 0, 11'd24, 0, 3'd0);
    addVec(0, 56, 8'h00, 0, 0, 0, 11'd24, 0, 3'd0);

    // Scenario 1: {5,0,0,0,0,0,0,2}
    addVec(1, 1,  8'h01, 1, 0, 0, 11'd0, 1, 3'd0);
    addVec(1, 5,  8'h01, 1, 0, 0, 11'd4, 1, 3'd0);
    addVec(1, 6,  8'h00, 1, 0, 0, 11'd5, 0, 3'd0);
    addVec(1, 7,  8'h00, 1, 0, 0, 11'd5, 0, 3'd0);
    addVec(1, 8,  8'h00, 1, 0, 0, 11'd5, 1, 3'd1);
    addVec(1, 13, 8'h00, 1, 0, 0, 11'd5, 1, 3'd6);
    addVec(1, 14, 8'h80, 1, 0, 0, 11'd5, 1, 3'd7);
    addVec(1, 15, 8'h80, 1, 0, 0, 11'd6, 1, 3'd7);
    addVec(1, 16, 8'h00, 1, 0, 0, 11'd7, 0, 3'd0);
    addVec(1, 31, 8'h00, 1, 0, 0, 11'd7, 0, 3'd0);
    addVec(1, 32, 8'h00, 1, 1, 0, 11'd7, 0, 3'd0);
    addVec(1, 33, 8'h00, 0, 0, 0, 11'd7, 0, 3'd0);

    // Scenario 2: all durations 0
    addVec(2, 1,  8'h00, 1, 0, 0, 11'd0, 1, 3'd0);
    addVec(2, 4,  8'h00, 1, 0, 0, 11'd0, 1, 3'd3);
    addVec(2, 8,  8'h00, 1, 0, 0, 11'd0, 1, 3'd7);
    addVec(2, 24, 8'h00, 1, 0, 0, 11'd0, 0, 3'd0);
    addVec(2, 25, 8'h00, 1, 1, 0, 11'd0, 0, 3'd0);
    addVec(2, 26, 8'h00, 0, 0, 0, 11'd0, 0, 3'd0);

    // Scenario 3: all 3, abort during cycle 7
    addVec(3, 7, 8'h02, 1, 0, 0, 11'd4, 1, 3'd1);
    addVec(3, 8, 8'h00, 0, 0, 1, 11'd4, 0, 3'd0);
    addVec(3, 9, 8'h00, 0, 0, 0, 11'd4, 0, 3'd0);

    // Scenario 4: abort coincides with the ch0 expiry in cycle 3
    addVec(4, 3, 8'h01, 1, 0, 0, 11'd2, 1, 3'd0);
    addVec(4, 4, 8'h00, 0, 0, 1, 11'd2, 0, 3'd0);
    addVec(4, 6, 8'h00, 0, 0, 0, 11'd2, 0, 3'd0);

    // Scenario 5: all 0, abort while in DONE (cycle 25)
    addVec(5, 25, 8'h00, 1, 1, 0, 11'd0, 0, 3'd0);
    addVec(5, 26, 8'h00, 0, 0, 0, 11'd0, 0, 3'd0);

    repeat (3) @(posedge clk);
    #1;
    cmp("reset_valve",   0, 32'(valve_open),  32'd0);
    cmp("reset_busy",    0, 32'(busy),        32'd0);
    cmp("reset_done",    0, 32'(done),        32'd0);
    cmp("reset_aborted", 0, 32'(aborted),     32'd0);
    cmp("reset_ticks",   0, 32'(total_ticks), 32'd0);
    cmp("reset_chan",    0, 32'(chan_idx),    32'd0);
    #3 rst = 1'b0;

    $display("[TB] all durations 3");
    applyStimulus(ALL3, 60, -1, -1);
    checkOutput(0, 1, 0);

    $display("[TB] mixed durations with skips");
    applyStimulus(MIXED, 36, -1, -1);
    checkOutput(1, 1, 0);

    $display("[TB] all durations 0");
    applyStimulus(ALL0, 30, -1, -1);
    checkOutput(2, 1, 0);
    cmp("valve_never_open", 2, 32'(valveOr), 32'd0);

    $display("[TB] abort mid-dispense");
    applyStimulus(ALL3, 15, 7, -1);
    checkOutput(3, 0, 1);

    $display("[TB] abort on expiry");
    applyStimulus(ALL3, 10, 3, -1);
    checkOutput(4, 0, 1);

    $display("[TB] abort in DONE");
    applyStimulus(ALL0, 30, 25, -1);
    checkOutput(5, 1, 0);

    $display("[TB] start while busy ignored");
    applyStimulus(ALL3, 60, -1, 20);
    checkOutput(0, 1, 0);

    $display("[TB] abort in IDLE ignored");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cmp("idle_abort_aborted", 0, 32'(aborted), 32'd0);
    cmp("idle_abort_busy",    0, 32'(busy),    32'd0);
    cmp("idle_abort_ticks",   0, 32'(total_ticks), 32'd24);

    $display("[TB] async reset mid-dispense");
    @(posedge clk); #1;
    dur_in = ALL3;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(posedge clk); #1;
    cmp("pre_reset_valve", 2, 32'(valve_open), 32'h01);
    #3 rst = 1'b1;
    #1;
    cmp("async_rst_valve", 0, 32'(valve_open),  32'd0);
    cmp("async_rst_busy",  0, 32'(busy),        32'd0);
    cmp("async_rst_ticks", 0, 32'(total_ticks), 32'd0);
    cmp("async_rst_chan",  0, 32'(chan_idx),    32'd0);
    #2 rst = 1'b0;
    applyStimulus(ALL3, 60, -1, -1);
    checkOutput(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
